pipeline_run_controller: RTL and testbench

- Run-control and hazard sequencer for the 8-bit-PC / 29-bit-instruction processor core. It sits between the instruction register, control unit and register file.
- Gates PC advance, instruction-register load and register-file write enable.
- Inserts stall bubbles on read-after-write hazards, flushes after jumps, and provides halt / single-step / resume debug control.
- Also stops the core on a HALT opcode.

---
 rtl/pipeline_run_controller.sv | 151 +++++++++++++++
 tb/tb_pipeline_run_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_controller.sv
// Run-control and hazard sequencer for the 8-bit-PC / 29-bit-instruction core.
// Gates PC/IR loads and register-file writes; handles RAW stalls, jump flushes and debug halt/step.
module pipeline_run_controller #(
    parameter int unsigned          ADDR_W      = 8,
    parameter int unsigned          OPCODE_W    = 5,
    parameter int unsigned          WB_LATENCY  = 1,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE = 5'h1F
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic [OPCODE_W-1:0] in_op_code,
    input  logic [ADDR_W-1:0]   in_dest_add,
    input  logic [ADDR_W-1:0]   in_src1_add,
    input  logic [ADDR_W-1:0]   in_src2_add,
    input  logic                in_src1_used,
    input  logic                in_src2_used,
    input  logic                in_wr_en,
    input  logic                in_jump,
    input  logic                in_dbg_halt,
    input  logic                in_dbg_step,
    input  logic                in_dbg_resume,
    output logic                out_pc_en,
    output logic                out_ir_en,
    output logic                out_ir_flush,
    output logic                out_wr_en_gated,
    output logic                out_stall,
    output logic                out_halted,
    output logic [15:0]         out_stall_count
);

    localparam int unsigned CNT_W = (WB_LATENCY > 0) ? $clog2(WB_LATENCY + 1) : 1;

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_HALT  = 3'd3,
        S_STEP  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pend_add;
    logic [CNT_W-1:0]    pend_cnt;
    logic [15:0]         stall_count;
    logic                hazard_c;
    logic                halt_req_c;
    logic                issue_c;

    // RAW hazard against the single outstanding write; address 0 is not special
    always_comb begin
        hazard_c = (pend_cnt != '0) &&
                   ((in_src1_used && (in_src1_add == pend_add)) ||
                    (in_src2_used && (in_src2_add == pend_add)));
        halt_req_c = in_dbg_halt || (in_op_code == HALT_OPCODE);
    end

    // Next-state and Mealy output decode
    always_comb begin
        state_nxt       = state;
        issue_c         = 1'b0;
        out_pc_en       = 1'b0;
        out_ir_en       = 1'b0;
        out_ir_flush    = 1'b0;
        out_wr_en_gated = 1'b0;
        out_stall       = 1'b0;
        out_halted      = 1'b0;

        case (state)
            S_FILL: begin
                out_pc_en = 1'b1;
                out_ir_en = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (halt_req_c) begin
                    state_nxt = S_HALT;
                end else if (hazard_c) begin
                    out_stall = 1'b1;
                end else begin
                    issue_c = 1'b1;
                    if (in_jump) state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                out_pc_en    = 1'b1;
                out_ir_en    = 1'b1;
                out_ir_flush = 1'b1;
                state_nxt    = S_RUN;
            end
            S_HALT: begin
                out_halted = 1'b1;
                if (in_dbg_resume && !in_dbg_halt) state_nxt = S_RUN;
                else if (in_dbg_step)              state_nxt = S_STEP;
            end
            S_STEP: begin
                // One RUN cycle with halt conditions masked; a stalled step leaves the IR in place
                out_halted = 1'b1;
                if (hazard_c) begin
                    out_stall = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    issue_c   = 1'b1;
                    state_nxt = in_jump ? S_FLUSH : S_HALT;
                end
            end
            default: state_nxt = S_FILL;
        endcase

        if (issue_c) begin
            out_pc_en       = 1'b1;
            out_ir_en       = 1'b1;
            out_wr_en_gated = in_wr_en;
        end

        // Reset forces every output low immediately, even mid-cycle
        if (in_rst) begin
            issue_c         = 1'b0;
            out_pc_en       = 1'b0;
            out_ir_en       = 1'b0;
            out_ir_flush    = 1'b0;
            out_wr_en_gated = 1'b0;
            out_stall       = 1'b0;
            out_halted      = 1'b0;
        end
    end

    // State, scoreboard and stall counter
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state       <= S_FILL;
            pend_add    <= '0;
            pend_cnt    <= '0;
            stall_count <= '0;
        end else begin
            state <= state_nxt;
            if (issue_c && in_wr_en) begin
                pend_add <= in_dest_add;
                pend_cnt <= CNT_W'(WB_LATENCY);
            end else if (pend_cnt != '0) begin
                pend_cnt <= pend_cnt - CNT_W'(1);
            end
            if (out_stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    assign out_stall_count = stall_count;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller: two instances (WB_LATENCY 1 and 2) on shared inputs.
module tb_pipeline_run_controller;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic [4:0]  in_op_code;
    logic [7:0]  in_dest_add, in_src1_add, in_src2_add;
    logic        in_src1_used, in_src2_used, in_wr_en, in_jump;
    logic        in_dbg_halt, in_dbg_step, in_dbg_resume;

    logic        pc1, ir1, fl1, wr1, st1, hl1;
    logic        pc2, ir2, fl2, wr2, st2, hl2;
    logic [15:0] cnt1, cnt2;
    logic [5:0]  o1, o2;

    int total = 0;
    int bad   = 0;

    always #5 in_clk = ~in_clk;

    assign o1 = {pc1, ir1, fl1, wr1, st1, hl1};
    assign o2 = {pc2, ir2, fl2, wr2, st2, hl2};

    pipeline_run_controller u_dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_op_code(in_op_code),
        .in_dest_add(in_dest_add), .in_src1_add(in_src1_add), .in_src2_add(in_src2_add),
        .in_src1_used(in_src1_used), .in_src2_used(in_src2_used), .in_wr_en(in_wr_en),
        .in_jump(in_jump), .in_dbg_halt(in_dbg_halt), .in_dbg_step(in_dbg_step),
        .in_dbg_resume(in_dbg_resume), .out_pc_en(pc1), .out_ir_en(ir1),
        .out_ir_flush(fl1), .out_wr_en_gated(wr1), .out_stall(st1), .out_halted(hl1),
        .out_stall_count(cnt1)
    );

    pipeline_run_controller #(.WB_LATENCY(2)) u_dut2 (
        .in_clk(in_clk), .in_rst(in_rst), .in_op_code(in_op_code),
        .in_dest_add(in_dest_add), .in_src1_add(in_src1_add), .in_src2_add(in_src2_add),
        .in_src1_used(in_src1_used), .in_src2_used(in_src2_used), .in_wr_en(in_wr_en),
        .in_jump(in_jump), .in_dbg_halt(in_dbg_halt), .in_dbg_step(in_dbg_step),
        .in_dbg_resume(in_dbg_resume), .out_pc_en(pc2), .out_ir_en(ir2),
        .out_ir_flush(fl2), .out_wr_en_gated(wr2), .out_stall(st2), .out_halted(hl2),
        .out_stall_count(cnt2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // op, dest, src1, src2, src1_used, src2_used, wr_en, jump
    task automatic instr(input logic [4:0] op, input logic [7:0] d, input logic [7:0] s1,
                         input logic [7:0] s2, input logic u1, input logic u2,
                         input logic wr, input logic jmp);
        in_op_code   = op;
        in_dest_add  = d;
        in_src1_add  = s1;
        in_src2_add  = s2;
        in_src1_used = u1;
        in_src2_used = u2;
        in_wr_en     = wr;
        in_jump      = jmp;
    endtask

    // Output vector order: {pc_en, ir_en, ir_flush, wr_en_gated, stall, halted}
    initial begin
        in_rst = 1'b1;
        in_dbg_halt = 1'b0; in_dbg_step = 1'b0; in_dbg_resume = 1'b0;
        instr(5'h00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        #1;
        chk("rst_out1", 16'(o1), 16'h0);
        chk("rst_out2", 16'(o2), 16'h0);
        chk("rst_cnt1", cnt1, 16'd0);

        in_rst = 1'b0; #1;
        chk("fill1", 16'(o1), 16'(6'b110000));
        chk("fill2", 16'(o2), 16'(6'b110000));
        tick();

        // Independent instructions
        instr(5'h01, 8'd1, 8'd2, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        chk("run_a", 16'(o1), 16'(6'b110100));
        tick();
        instr(5'h02, 8'd3, 8'd4, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        chk("run_b", 16'(o1), 16'(6'b110100));
        tick();
        instr(5'h03, 8'd5, 8'd6, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        chk("run_c1", 16'(o1), 16'(6'b110100));
        chk("run_c2", 16'(o2), 16'(6'b110100));
        chk("run_cnt0", cnt1, 16'd0);
        tick();

        // Read r5 via src2 right after write to r5
        instr(5'h04, 8'd7, 8'd0, 8'd5, 1'b0, 1'b1, 1'b1, 1'b0); #1;
        chk("haz_s1_l1", 16'(o1), 16'(6'b000010));
        chk("haz_s1_l2", 16'(o2), 16'(6'b000010));
        tick();
        chk("haz_iss_l1", 16'(o1), 16'(6'b110100));
        chk("haz_s2_l2", 16'(o2), 16'(6'b000010));
        tick();
        chk("haz_iss_l2", 16'(o2), 16'(6'b110100));
        chk("haz_cnt_l1", cnt1, 16'd1);
        chk("haz_cnt_l2", cnt2, 16'd2);
        tick();

        // Jump without hazard
        instr(5'h05, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        chk("jmp_iss", 16'(o1), 16'(6'b110100));
        tick();
        instr(5'h06, 8'd8, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        chk("jmp_flush", 16'(o1), 16'(6'b111000));
        tick();
        instr(5'h06, 8'd8, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("jmp_run", 16'(o1), 16'(6'b110000));
        tick();

        // Jump colliding with hazard: stall, then jump issues, then flush
        instr(5'h07, 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        chk("jh_wr", 16'(o1), 16'(6'b110100));
        tick();
        instr(5'h08, 8'd0, 8'd10, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1); #1;
        chk("jh_stall", 16'(o1), 16'(6'b000010));
        tick();
        chk("jh_iss", 16'(o1), 16'(6'b110000));
        tick();
        instr(5'h00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("jh_flush", 16'(o1), 16'(6'b111000));
        tick();
        chk("jh_run", 16'(o1), 16'(6'b110000));
        chk("jh_cnt", cnt1, 16'd2);
        tick();

        // HALT opcode, two single steps, resume
        instr(5'h1F, 8'd11, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        chk("hop_run", 16'(o1), 16'(6'b000000));
        tick();
        chk("hop_halt", 16'(o1), 16'(6'b000001));
        tick();
        in_dbg_step = 1'b1; #1;
        chk("hop_req1", 16'(o1), 16'(6'b000001));
        tick();
        in_dbg_step = 1'b0; #1;
        chk("step1", 16'(o1), 16'(6'b110101));
        tick();
        instr(5'h09, 8'd12, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        chk("step1_halt", 16'(o1), 16'(6'b000001));
        tick();
        in_dbg_step = 1'b1; #1;
        chk("hop_req2", 16'(o1), 16'(6'b000001));
        tick();
        in_dbg_step = 1'b0; #1;
        chk("step2", 16'(o1), 16'(6'b110101));
        tick();
        instr(5'h02, 8'd0, 8'd12, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        chk("step2_halt", 16'(o1), 16'(6'b000001));
        tick();
        in_dbg_resume = 1'b1; #1;
        chk("resume_req", 16'(o1), 16'(6'b000001));
        tick();
        in_dbg_resume = 1'b0; #1;
        chk("resume_run", 16'(o1), 16'(6'b110000));
        tick();

        // Debug halt level blocks resume until it drops
        instr(5'h00, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_dbg_halt = 1'b1; #1;
        chk("dh_run", 16'(o1), 16'(6'b000000));
        tick();
        in_dbg_resume = 1'b1; #1;
        chk("dh_blocked", 16'(o1), 16'(6'b000001));
        tick();
        in_dbg_resume = 1'b0; #1;
        chk("dh_still", 16'(o1), 16'(6'b000001));
        tick();
        in_dbg_halt = 1'b0; in_dbg_resume = 1'b1; #1;
        chk("dh_release", 16'(o1), 16'(6'b000001));
        tick();
        in_dbg_resume = 1'b0; #1;
        chk("dh_run2", 16'(o1), 16'(6'b110000));
        tick();

        // Reset during a stall
        instr(5'h0A, 8'd13, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
        chk("rs_wr", 16'(o1), 16'(6'b110100));
        tick();
        instr(5'h0B, 8'd0, 8'd13, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        chk("rs_stall", 16'(o1), 16'(6'b000010));
        in_rst = 1'b1; #1;
        chk("rs_out", 16'(o1), 16'h0);
        chk("rs_cnt", cnt1, 16'd0);
        tick();
        in_rst = 1'b0; #1;
        chk("rs_fill", 16'(o1), 16'(6'b110000));
        tick();
        chk("rs_run", 16'(o1), 16'(6'b110000));
        chk("rs_cnt2", cnt1, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
